// File: rtl/crc_stream_engine.sv
// crc_stream_engine
//   Streaming CRC engine following the Rocksoft parameter model. Beats of
//   DWIDTH bits are folded into the CRC register one whole beat per cycle,
//   MSB byte first. The frame configuration is captured on the start-of-frame
//   beat, and the result is held on a valid/ready output until it is taken.
//
// Ports
//   clk, rstN                     clock, asynchronous active-low reset
//   inValid/inReady               input beat handshake
//   inData, inSof, inLast         beat payload and frame delimiters
//   inBytes                       valid bytes on the last beat (0 = all)
//   genPoly, initValue,
//   finalXorValue, refInEn,
//   refOutEn                      CRC configuration, sampled on inSof
//   crcValid/crcReady, crcOut     result handshake
//   busy                          frame in progress or result pending
//   sofErr                        one-cycle framing error pulse
//
// State | meaning
//   IDLE | waiting for a start-of-frame beat
//   RUN  | frame open, accumulating beats
//   DONE | result presented, waiting for crcReady

module crc_stream_engine #(
  parameter int CRC_WIDTH = 16,
  parameter int DWIDTH    = 32
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [DWIDTH-1:0]            inData,
  input  logic                         inSof,
  input  logic                         inLast,
  input  logic [$clog2(DWIDTH/8):0]    inBytes,
  input  logic [CRC_WIDTH-1:0]         genPoly,
  input  logic [CRC_WIDTH-1:0]         initValue,
  input  logic [CRC_WIDTH-1:0]         finalXorValue,
  input  logic                         refInEn,
  input  logic                         refOutEn,
  output logic                         crcValid,
  input  logic                         crcReady,
  output logic [CRC_WIDTH-1:0]         crcOut,
  output logic                         busy,
  output logic                         sofErr
);

  localparam int NB = DWIDTH / 8;
  localparam int BW = $clog2(NB) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, stateNext;
  logic [CRC_WIDTH-1:0] crcReg, crcNext;
  logic [CRC_WIDTH-1:0] polyReg, xorReg;
  logic                 refInReg, refOutReg;
  logic                 loadCrc, loadCfg, sofErrNext;

  // Working variables of the beat-folding network
  logic [CRC_WIDTH-1:0] usePoly;
  logic                 useRefIn;
  logic [BW-1:0]        nBytes;
  logic [7:0]           byteVal;
  logic                 fb;
  logic [CRC_WIDTH-1:0] crcRefl;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Outputs decode from state alone, so inReady never depends on inValid.
  assign inReady  = (state != DONE);
  assign crcValid = (state == DONE);
  assign busy     = (state != IDLE);

  always_comb begin
    stateNext  = state;
    loadCrc    = 1'b0;
    loadCfg    = 1'b0;
    sofErrNext = 1'b0;
    case (state)
      IDLE: begin
        if (inValid) begin
          if (inSof) begin
            loadCrc   = 1'b1;
            loadCfg   = 1'b1;
            stateNext = inLast ? DONE : RUN;
          end else begin
            sofErrNext = 1'b1;
          end
        end
      end
      RUN: begin
        if (inValid) begin
          loadCrc = 1'b1;
          // A new SOF inside a frame aborts it and restarts from this beat.
          if (inSof) begin
            loadCfg    = 1'b1;
            sofErrNext = 1'b1;
          end
          stateNext = inLast ? DONE : RUN;
        end
      end
      DONE: begin
        if (crcReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Whole-beat CRC update. On a start beat the live configuration is used,
  // since the captured copy only becomes valid on the following cycle.
  always_comb begin
    usePoly  = loadCfg ? genPoly : polyReg;
    useRefIn = loadCfg ? refInEn : refInReg;
    crcNext  = loadCfg ? initValue : crcReg;
    if (inLast && (inBytes != '0) && (inBytes < BW'(NB))) nBytes = inBytes;
    else                                                  nBytes = BW'(NB);
    byteVal = '0;
    fb      = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(nBytes)) begin
        byteVal = inData[DWIDTH-1-8*i -: 8];
        if (useRefIn) byteVal = rev8(byteVal);
        for (int k = 7; k >= 0; k--) begin
          fb      = crcNext[CRC_WIDTH-1] ^ byteVal[k];
          crcNext = {crcNext[CRC_WIDTH-2:0], 1'b0};
          if (fb) crcNext = crcNext ^ usePoly;
        end
      end
    end
  end

  always_comb begin
    crcRefl = '0;
    for (int i = 0; i < CRC_WIDTH; i++) crcRefl[i] = crcReg[CRC_WIDTH-1-i];
    crcOut = (refOutReg ? crcRefl : crcReg) ^ xorReg;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      crcReg    <= '0;
      polyReg   <= '0;
      xorReg    <= '0;
      refInReg  <= 1'b0;
      refOutReg <= 1'b0;
      sofErr    <= 1'b0;
    end else begin
      state  <= stateNext;
      sofErr <= sofErrNext;
      if (loadCrc) crcReg <= crcNext;
      if (loadCfg) begin
        polyReg   <= genPoly;
        xorReg    <= finalXorValue;
        refInReg  <= refInEn;
        refOutReg <= refOutEn;
      end
    end
  end

endmodule
